// File: rtl/dekatron_bin_codec_pkg.sv
`timescale 1ns/1ps
// Shared types, constants and per-decade coding helpers for the dekatron codec.
package dekatron_pkg;

    localparam int DEK_POS = 10;  // cathode positions per dekatron tube
    localparam int BCD_W   = 4;   // bits per 8-4-2-1 digit

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DABBLE = 2'd1,
        HORNER = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Decoded tube position: digit plus a flag saying the one-hot was well formed.
    typedef struct packed {
        logic       valid;
        logic [3:0] digit;
    } pos_dec_t;

    // BCD digit to one-hot tube position; codes 10..15 select no cathode.
    function automatic logic [DEK_POS-1:0] bcd_to_pos(input logic [BCD_W-1:0] bcd);
        logic [DEK_POS-1:0] pos;
        pos = 10'd0;
        for (int i = 0; i < DEK_POS; i++) begin
            pos[i] = (bcd == 4'(i));
        end
        return pos;
    endfunction

    // One-hot tube position to BCD; anything but exactly one set bit yields 0/invalid.
    function automatic pos_dec_t pos_to_bcd(input logic [DEK_POS-1:0] pos);
        pos_dec_t   r;
        logic [3:0] ones;
        ones    = 4'd0;
        r.digit = 4'd0;
        for (int i = 0; i < DEK_POS; i++) begin
            ones    = ones + {3'd0, pos[i]};
            r.digit = pos[i] ? 4'(i) : r.digit;
        end
        r.valid = (ones == 4'd1);
        r.digit = r.valid ? r.digit : 4'd0;
        return r;
    endfunction

    // 10^n, used to check that the binary word can hold every decimal value.
    function automatic longint unsigned pow10_u(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/dekatron_bin_codec_if.sv
`timescale 1ns/1ps
// Request/result bundle between the binary datapath and the dekatron codec.
interface dekatron_bin_codec_if
    import dekatron_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int BIN_WIDTH = 14
) ();

    logic                        request;
    logic                        dir;
    logic [BIN_WIDTH-1:0]        bin_in;
    logic [DIGITS*DEK_POS-1:0]   pos_in;
    logic                        ready;
    logic                        valid;
    logic [BIN_WIDTH-1:0]        bin_out;
    logic [DIGITS*BCD_W-1:0]     bcd_out;
    logic [DIGITS*DEK_POS-1:0]   pos_out;
    logic                        error;

    modport master (
        output request, dir, bin_in, pos_in,
        input  ready, valid, bin_out, bcd_out, pos_out, error
    );

    modport slave (
        input  request, dir, bin_in, pos_in,
        output ready, valid, bin_out, bcd_out, pos_out, error
    );

endinterface

// File: rtl/dekatron_bin_codec_digit.sv
`timescale 1ns/1ps
// One decade: one-hot tube input to BCD with validity, and BCD back to one-hot.
module dek_digit_codec
    import dekatron_pkg::*;
(
    input  logic [DEK_POS-1:0] pos_i,
    output logic [BCD_W-1:0]   bcd_o,
    output logic               valid_o,
    input  logic [BCD_W-1:0]   bcd_i,
    output logic [DEK_POS-1:0] pos_o
);

    pos_dec_t dec_s;

    // Pure combinational decode/encode of a single tube.
    always_comb begin
        dec_s   = pos_to_bcd(pos_i);
        bcd_o   = dec_s.digit;
        valid_o = dec_s.valid;
        pos_o   = bcd_to_pos(bcd_i);
    end

endmodule

// File: rtl/dekatron_bin_codec.sv
`timescale 1ns/1ps
// Sequential binary <-> dekatron converter: double dabble one way, Horner x10 the other.
module dekatron_bin_codec
    import dekatron_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int BIN_WIDTH = 14
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    dekatron_bin_codec_if.slave  bus
);

    localparam int BCD_TOT = DIGITS * BCD_W;
    localparam int POS_TOT = DIGITS * DEK_POS;
    localparam int CNT_W   = $clog2(BIN_WIDTH + 1);
    localparam longint unsigned DEC_MAX = pow10_u(DIGITS) - 64'd1;
    // Every tube parked on cathode 0.
    localparam logic [POS_TOT-1:0] POS_ZERO = {DIGITS{10'b00_0000_0001}};

    if ((64'd1 << BIN_WIDTH) <= DEC_MAX) begin : g_bad_width
        $error("BIN_WIDTH too small to hold 10^DIGITS-1");
    end

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0] shift_q, shift_d;
    logic [BCD_TOT-1:0]   bcd_q, bcd_d;
    logic [BIN_WIDTH-1:0] acc_q, acc_d;
    logic [BIN_WIDTH-1:0] bin_cap_q, bin_cap_d;
    logic [BCD_TOT-1:0]   digits_q, digits_d;
    logic                 dir_q, dir_d;
    logic                 err_q, err_d;
    logic                 ready_q, ready_d;
    logic                 valid_q, valid_d;
    logic [BIN_WIDTH-1:0] bin_out_q, bin_out_d;
    logic [BCD_TOT-1:0]   bcd_out_q, bcd_out_d;
    logic [POS_TOT-1:0]   pos_out_q, pos_out_d;
    logic                 error_q, error_d;

    logic [BCD_TOT-1:0]   adj_s;        // BCD accumulator after add-3 correction
    logic [BCD_TOT-1:0]   dec_bcd_s;    // sanitized digits decoded from pos_in
    logic [DIGITS-1:0]    dec_valid_s;
    logic [BCD_TOT-1:0]   res_bcd_s;    // digits to be published this conversion
    logic [POS_TOT-1:0]   enc_pos_s;
    logic [BCD_W-1:0]     digit_sel_s;  // decade consumed by the current Horner step

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        logic [BCD_W-1:0] nib_s;
        assign nib_s = bcd_q[g*BCD_W +: BCD_W];
        assign adj_s[g*BCD_W +: BCD_W] = (nib_s >= 4'd5) ? (nib_s + 4'd3) : nib_s;

        dek_digit_codec u_codec (
            .pos_i   (bus.pos_in[g*DEK_POS +: DEK_POS]),
            .bcd_o   (dec_bcd_s[g*BCD_W +: BCD_W]),
            .valid_o (dec_valid_s[g]),
            .bcd_i   (res_bcd_s[g*BCD_W +: BCD_W]),
            .pos_o   (enc_pos_s[g*DEK_POS +: DEK_POS])
        );
    end

    assign res_bcd_s = dir_q ? digits_q : bcd_q;

    // Pick the decade indexed by the down-counter (most significant first).
    always_comb begin
        digit_sel_s = 4'd0;
        for (int d = 0; d < DIGITS; d++) begin
            digit_sel_s = (cnt_q == CNT_W'(d)) ? digits_q[d*BCD_W +: BCD_W] : digit_sel_s;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Ready is only ever high in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.request) begin
                    state_d = bus.dir ? HORNER : DABBLE;
                end else begin
                    state_d = IDLE;
                end
            end
            DABBLE, HORNER: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = state_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values for each state.
    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        acc_d     = acc_q;
        bin_cap_d = bin_cap_q;
        digits_d  = digits_q;
        dir_d     = dir_q;
        err_d     = err_q;
        ready_d   = ready_q;
        valid_d   = 1'b0;
        bin_out_d = bin_out_q;
        bcd_out_d = bcd_out_q;
        pos_out_d = pos_out_q;
        error_d   = error_q;
        case (state_q)
            IDLE: begin
                if (bus.request) begin
                    ready_d   = 1'b0;
                    dir_d     = bus.dir;
                    bin_cap_d = bus.bin_in;
                    shift_d   = bus.bin_in;
                    bcd_d     = '0;
                    acc_d     = '0;
                    digits_d  = dec_bcd_s;
                    if (bus.dir) begin
                        err_d = ~(&dec_valid_s);
                        cnt_d = CNT_W'(DIGITS - 1);
                    end else begin
                        err_d = 1'b0;
                        cnt_d = CNT_W'(BIN_WIDTH - 1);
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            DABBLE: begin
                // Correct, then shift {BCD, bin}; a bit leaving the top nibble is lost weight 10^DIGITS.
                bcd_d   = {adj_s[BCD_TOT-2:0], shift_q[BIN_WIDTH-1]};
                shift_d = {shift_q[BIN_WIDTH-2:0], 1'b0};
                err_d   = err_q | adj_s[BCD_TOT-1];
                cnt_d   = cnt_q - CNT_W'(1);
            end
            HORNER: begin
                acc_d = (acc_q << 3) + (acc_q << 1) + BIN_WIDTH'(digit_sel_s);
                cnt_d = cnt_q - CNT_W'(1);
            end
            DONE: begin
                ready_d   = 1'b1;
                valid_d   = 1'b1;
                bin_out_d = dir_q ? acc_q : bin_cap_q;
                bcd_out_d = res_bcd_s;
                pos_out_d = enc_pos_s;
                error_d   = err_q;
            end
            default: begin
                ready_d = 1'b1;
            end
        endcase
    end

    // Datapath and registered outputs; reset also abandons any conversion in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            shift_q   <= '0;
            bcd_q     <= '0;
            acc_q     <= '0;
            bin_cap_q <= '0;
            digits_q  <= '0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            bin_out_q <= '0;
            bcd_out_q <= '0;
            pos_out_q <= POS_ZERO;
            error_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            acc_q     <= acc_d;
            bin_cap_q <= bin_cap_d;
            digits_q  <= digits_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            bin_out_q <= bin_out_d;
            bcd_out_q <= bcd_out_d;
            pos_out_q <= pos_out_d;
            error_q   <= error_d;
        end
    end

    assign bus.ready   = ready_q;
    assign bus.valid   = valid_q;
    assign bus.bin_out = bin_out_q;
    assign bus.bcd_out = bcd_out_q;
    assign bus.pos_out = pos_out_q;
    assign bus.error   = error_q;

endmodule
